// File: rtl/mips_pkg.sv
// Shared opcodes, FSM states, ALU ops and instruction decoder for the multicycle MIPS core.
// Build option MIPS_SUBWORD_EN adds lb/lbu/lh/lhu/sb/sh decoding.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI
    } alu_op_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_J, CL_JAL, CL_JR
    } inst_class_e;

    typedef struct packed {
        inst_class_e cls;
        alu_op_e     alu_op;
        logic        zero_ext;
        logic        is_bne;
    } decode_t;

    // The all-zero word (sll $0,$0,0) is treated as a true nop, not an sll.
    function automatic decode_t decode(input logic [31:0] ir);
        decode_t d;
        d.cls      = CL_NOP;
        d.alu_op   = ALU_ADD;
        d.zero_ext = 1'b0;
        d.is_bne   = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                if (ir != 32'h0) begin
                    case (ir[5:0])
                        FN_ADDU: begin d.cls = CL_ALU_R; d.alu_op = ALU_ADD; end
                        FN_SUBU: begin d.cls = CL_ALU_R; d.alu_op = ALU_SUB; end
                        FN_AND:  begin d.cls = CL_ALU_R; d.alu_op = ALU_AND; end
                        FN_OR:   begin d.cls = CL_ALU_R; d.alu_op = ALU_OR;  end
                        FN_SLT:  begin d.cls = CL_ALU_R; d.alu_op = ALU_SLT; end
                        FN_SLL:  begin d.cls = CL_ALU_R; d.alu_op = ALU_SLL; end
                        FN_JR:   d.cls = CL_JR;
                        default: d.cls = CL_NOP;
                    endcase
                end
            end
            OP_ORI:   begin d.cls = CL_ALU_I; d.alu_op = ALU_OR;  d.zero_ext = 1'b1; end
            OP_ADDIU: begin d.cls = CL_ALU_I; d.alu_op = ALU_ADD; end
            OP_LUI:   begin d.cls = CL_ALU_I; d.alu_op = ALU_LUI; d.zero_ext = 1'b1; end
            OP_LW:    d.cls = CL_LOAD;
            OP_SW:    d.cls = CL_STORE;
            OP_BEQ:   d.cls = CL_BRANCH;
            OP_BNE:   begin d.cls = CL_BRANCH; d.is_bne = 1'b1; end
            OP_J:     d.cls = CL_J;
            OP_JAL:   d.cls = CL_JAL;
`ifdef MIPS_SUBWORD_EN
            OP_LB, OP_LBU, OP_LH, OP_LHU: d.cls = CL_LOAD;
            OP_SB, OP_SH:                 d.cls = CL_STORE;
`endif
            default:  d.cls = CL_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_grf.sv
// 32x32 general register file: two async read ports, one sync write port, $0 reads as zero.
module mips_grf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : regs_q[ra2_i];

endmodule

// File: rtl/mips.sv
// Multicycle MIPS-32 core (FETCH/DECODE/EXEC/MEM/WB) with commit-trace outputs.
// Build option MIPS_SUBWORD_EN enables byte/halfword loads and stores.
module mips
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ipc_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rd1, rd2, imm_ext, alu_b, alu_res;
    logic [31:0] pc_plus4, branch_target, jump_target, load_data;
    logic        taken;
    decode_t     dec;

    assign dec           = decode(ir_q);
    assign imm_ext       = dec.zero_ext ? {16'h0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
    assign alu_b         = (dec.cls == CL_ALU_R) ? b_q : imm_ext;
    assign pc_plus4      = ipc_q + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign taken         = (a_q == b_q) ^ dec.is_bne;

    always_comb begin
        alu_res = a_q + alu_b;
        case (dec.alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {31'h0, $signed(a_q) < $signed(alu_b)};
            ALU_SLL: alu_res = b_q << ir_q[10:6];
            ALU_LUI: alu_res = {ir_q[15:0], 16'h0};
            default: alu_res = a_q + alu_b;
        endcase
    end

    // Branches and jumps resolve in EXEC; PC already holds IPC+4 by then.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_FETCH: begin
                pc_d    = pc_q + 32'd4;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = (dec.cls == CL_NOP) ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                case (dec.cls)
                    CL_BRANCH: begin
                        if (taken) pc_d = branch_target;
                        state_d = ST_FETCH;
                    end
                    CL_J: begin
                        pc_d    = jump_target;
                        state_d = ST_FETCH;
                    end
                    CL_JAL: begin
                        pc_d    = jump_target;
                        state_d = ST_WB;
                    end
                    CL_JR: begin
                        pc_d    = a_q;
                        state_d = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM:  state_d = (dec.cls == CL_LOAD) ? ST_WB : ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            ipc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            case (state_q)
                ST_FETCH: begin
                    ir_q  <= i_inst_rdata;
                    ipc_q <= pc_q;
                end
                ST_DECODE: begin
                    a_q <= rd1;
                    b_q <= rd2;
                end
                ST_EXEC: alu_q <= (dec.cls == CL_JAL) ? pc_plus4 : alu_res;
                ST_MEM:  mdr_q <= m_data_rdata;
                default: ;
            endcase
        end
    end

`ifdef MIPS_SUBWORD_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_byte = mdr_q[{alu_q[1:0], 3'b000} +: 8];
    assign load_half = alu_q[1] ? mdr_q[31:16] : mdr_q[15:0];

    always_comb begin
        m_data_wdata  = b_q;
        m_data_byteen = 4'b0000;
        case (ir_q[31:26])
            OP_SB: begin
                m_data_wdata  = {4{b_q[7:0]}};
                m_data_byteen = 4'b0001 << alu_q[1:0];
            end
            OP_SH: begin
                m_data_wdata  = {2{b_q[15:0]}};
                m_data_byteen = alu_q[1] ? 4'b1100 : 4'b0011;
            end
            default: m_data_byteen = 4'b1111;
        endcase
        if (!((state_q == ST_MEM) && (dec.cls == CL_STORE))) m_data_byteen = 4'b0000;
    end

    always_comb begin
        case (ir_q[31:26])
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h0, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0, load_half};
            default: load_data = mdr_q;
        endcase
    end
`else
    assign m_data_wdata  = b_q;
    assign m_data_byteen = ((state_q == ST_MEM) && (dec.cls == CL_STORE)) ? 4'b1111 : 4'b0000;
    assign load_data     = mdr_q;
`endif

    assign i_inst_addr = pc_q;
    assign m_data_addr = alu_q;
    assign m_inst_addr = ipc_q;
    assign w_inst_addr = ipc_q;
    assign w_grf_we    = (state_q == ST_WB);
    assign w_grf_wdata = (dec.cls == CL_LOAD) ? load_data : alu_q;

    always_comb begin
        case (dec.cls)
            CL_ALU_R: w_grf_addr = ir_q[15:11];
            CL_JAL:   w_grf_addr = 5'd31;
            default:  w_grf_addr = ir_q[20:16];
        endcase
    end

    mips_grf u_grf (
        .clk_i  (clk),
        .rst_ni (reset),
        .ra1_i  (ir_q[25:21]),
        .ra2_i  (ir_q[20:16]),
        .rd1_o  (rd1),
        .rd2_o  (rd2),
        .we_i   (w_grf_we),
        .wa_i   (w_grf_addr),
        .wd_i   (w_grf_wdata)
    );

endmodule

// File: tb/tb_mips.sv
// Directed program bench for the multicycle MIPS core: checks reset state, cycle-exact
// register commits and stores, control-flow targets and reset during a store.
module tb_mips;

    logic        clk;
    logic        reset;
    logic [31:0] i_inst_addr, i_inst_rdata;
    logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata, w_inst_addr;

    logic [31:0] imem [64];
    logic [31:0] dmem [16];

    int testsRun;
    int testsFailed;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_ev_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] pc;
    } st_ev_t;

    wb_ev_t wbSeen[$];
    wb_ev_t wbExp[$];
    st_ev_t stSeen[$];
    st_ev_t stExp[$];

    mips dut (
        .clk           (clk),
        .reset         (reset),
        .i_inst_addr   (i_inst_addr),
        .i_inst_rdata  (i_inst_rdata),
        .m_data_addr   (m_data_addr),
        .m_data_rdata  (m_data_rdata),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .w_grf_we      (w_grf_we),
        .w_grf_addr    (w_grf_addr),
        .w_grf_wdata   (w_grf_wdata),
        .w_inst_addr   (w_inst_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_inst_rdata = imem[i_inst_addr[7:2]];
    assign m_data_rdata = dmem[m_data_addr[5:2]];

    // Byte-lane data memory, written on the same edge the core leaves MEM.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (m_data_byteen[l]) dmem[m_data_addr[5:2]][l*8 +: 8] <= m_data_wdata[l*8 +: 8];
    end

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        imem[6'h00] = itype(6'h0D, 0, 1, 16'h1234);       // 3000 ori  $1,$0,0x1234
        imem[6'h01] = itype(6'h0F, 0, 2, 16'hABCD);       // 3004 lui  $2,0xABCD
        imem[6'h02] = itype(6'h0D, 2, 2, 16'h00EF);       // 3008 ori  $2,$2,0xEF
        imem[6'h03] = itype(6'h2B, 0, 2, 16'h0008);       // 300C sw   $2,8($0)
        imem[6'h04] = itype(6'h23, 0, 3, 16'h0008);       // 3010 lw   $3,8($0)
        imem[6'h05] = itype(6'h04, 0, 0, 16'h0002);       // 3014 beq  $0,$0,+2
        imem[6'h06] = itype(6'h0D, 0, 5, 16'hDEAD);       // 3018 skipped
        imem[6'h07] = itype(6'h0D, 0, 5, 16'hBEEF);       // 301C skipped
        imem[6'h08] = jtype(6'h03, 32'h0000_3080);        // 3020 jal  0x3080
        imem[6'h09] = 32'h0;                              // 3024 nop
        imem[6'h0A] = rtype(1, 3, 6, 0, 6'h21);           // 3028 addu $6,$1,$3
        imem[6'h0B] = rtype(1, 3, 7, 0, 6'h23);           // 302C subu $7,$1,$3
        imem[6'h0C] = rtype(3, 1, 8, 0, 6'h2A);           // 3030 slt  $8,$3,$1
        imem[6'h0D] = rtype(0, 1, 9, 4, 6'h00);           // 3034 sll  $9,$1,4
        imem[6'h0E] = rtype(2, 1, 10, 0, 6'h24);          // 3038 and  $10,$2,$1
        imem[6'h0F] = rtype(1, 1, 0, 0, 6'h21);           // 303C addu $0,$1,$1
        imem[6'h10] = rtype(0, 1, 13, 0, 6'h25);          // 3040 or   $13,$0,$1
        imem[6'h11] = itype(6'h05, 0, 0, 16'h0005);       // 3044 bne  $0,$0,+5
        imem[6'h12] = itype(6'h28, 0, 2, 16'h0005);       // 3048 sb   $2,5($0)
        imem[6'h13] = itype(6'h20, 0, 4, 16'h0005);       // 304C lb   $4,5($0)
        imem[6'h14] = itype(6'h24, 0, 14, 16'h0005);      // 3050 lbu  $14,5($0)
        imem[6'h15] = jtype(6'h02, 32'h0000_30C0);        // 3054 j    0x30C0
        imem[6'h20] = itype(6'h09, 0, 11, 16'hFFFF);      // 3080 addiu $11,$0,-1
        imem[6'h21] = rtype(31, 0, 0, 0, 6'h08);          // 3084 jr   $31
        imem[6'h30] = jtype(6'h02, 32'h0000_30C0);        // 30C0 j    0x30C0

        wbExp.push_back('{4,  5'd1,  32'h0000_1234, 32'h3000});
        wbExp.push_back('{8,  5'd2,  32'hABCD_0000, 32'h3004});
        wbExp.push_back('{12, 5'd2,  32'hABCD_00EF, 32'h3008});
        wbExp.push_back('{21, 5'd3,  32'hABCD_00EF, 32'h3010});
        wbExp.push_back('{28, 5'd31, 32'h0000_3024, 32'h3020});
        wbExp.push_back('{32, 5'd11, 32'hFFFF_FFFF, 32'h3080});
        wbExp.push_back('{41, 5'd6,  32'hABCD_1323, 32'h3028});
        wbExp.push_back('{45, 5'd7,  32'h5433_1145, 32'h302C});
        wbExp.push_back('{49, 5'd8,  32'h0000_0001, 32'h3030});
        wbExp.push_back('{53, 5'd9,  32'h0001_2340, 32'h3034});
        wbExp.push_back('{57, 5'd10, 32'h0000_0024, 32'h3038});
        wbExp.push_back('{61, 5'd0,  32'h0000_2468, 32'h303C});
        wbExp.push_back('{65, 5'd13, 32'h0000_1234, 32'h3040});
        stExp.push_back('{16, 32'h8, 32'hABCD_00EF, 4'b1111, 32'h300C});
`ifdef MIPS_SUBWORD_EN
        wbExp.push_back('{77, 5'd4,  32'hFFFF_FFEF, 32'h304C});
        wbExp.push_back('{82, 5'd14, 32'h0000_00EF, 32'h3050});
        stExp.push_back('{72, 32'h5, 32'hEFEF_EFEF, 4'b0010, 32'h3048});
`endif
    endtask

    task automatic checkResetState();
        checkOutput("rst_i_inst_addr", i_inst_addr, 32'h0000_3000);
        checkOutput("rst_byteen", {28'h0, m_data_byteen}, 32'h0);
        checkOutput("rst_grf_we", {31'h0, w_grf_we}, 32'h0);
        checkOutput("rst_m_data_addr", m_data_addr, 32'h0);
        checkOutput("rst_m_data_wdata", m_data_wdata, 32'h0);
        checkOutput("rst_m_inst_addr", m_inst_addr, 32'h0);
        checkOutput("rst_grf_addr", {27'h0, w_grf_addr}, 32'h0);
        checkOutput("rst_grf_wdata", w_grf_wdata, 32'h0);
        checkOutput("rst_w_inst_addr", w_inst_addr, 32'h0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1 checkResetState();
        @(negedge clk);
        reset = 1'b1;

        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc > 1) @(negedge clk);
            #1;
            if (w_grf_we)
                wbSeen.push_back('{cyc, w_grf_addr, w_grf_wdata, w_inst_addr});
            if (m_data_byteen != 4'b0000)
                stSeen.push_back('{cyc, m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr});
            case (cyc)
                1:  checkOutput("fetch_first", i_inst_addr, 32'h0000_3000);
                25: checkOutput("fetch_after_beq", i_inst_addr, 32'h0000_3020);
                29: checkOutput("fetch_jal_target", i_inst_addr, 32'h0000_3080);
                36: checkOutput("fetch_jr_return", i_inst_addr, 32'h0000_3024);
                38: checkOutput("fetch_after_nop", i_inst_addr, 32'h0000_3028);
                69: checkOutput("fetch_after_bne", i_inst_addr, 32'h0000_3048);
                default: ;
            endcase
        end

        checkOutput("wb_count", 32'(wbSeen.size()), 32'(wbExp.size()));
        for (int i = 0; i < wbSeen.size() && i < wbExp.size(); i++) begin
            checkOutput($sformatf("wb%0d_cycle", i), 32'(wbSeen[i].cyc), 32'(wbExp[i].cyc));
            checkOutput($sformatf("wb%0d_addr", i), {27'h0, wbSeen[i].addr}, {27'h0, wbExp[i].addr});
            checkOutput($sformatf("wb%0d_data", i), wbSeen[i].data, wbExp[i].data);
            checkOutput($sformatf("wb%0d_pc", i), wbSeen[i].pc, wbExp[i].pc);
        end
        checkOutput("store_count", 32'(stSeen.size()), 32'(stExp.size()));
        for (int i = 0; i < stSeen.size() && i < stExp.size(); i++) begin
            checkOutput($sformatf("st%0d_cycle", i), 32'(stSeen[i].cyc), 32'(stExp[i].cyc));
            checkOutput($sformatf("st%0d_addr", i), stSeen[i].addr, stExp[i].addr);
            checkOutput($sformatf("st%0d_data", i), stSeen[i].data, stExp[i].data);
            checkOutput($sformatf("st%0d_byteen", i), {28'h0, stSeen[i].be}, {28'h0, stExp[i].be});
            checkOutput($sformatf("st%0d_pc", i), stSeen[i].pc, stExp[i].pc);
        end
        checkOutput("dmem_word2", dmem[2], 32'hABCD_00EF);

        // Rerun the program and pull reset while the sw is in its MEM cycle.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc > 1) @(negedge clk);
            #1;
        end
        checkOutput("mid_sw_byteen", {28'h0, m_data_byteen}, 32'hF);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_sw_byteen", {28'h0, m_data_byteen}, 32'h0);
        checkOutput("rst_mid_sw_pc", i_inst_addr, 32'h0000_3000);
        checkOutput("rst_mid_sw_grf_we", {31'h0, w_grf_we}, 32'h0);
        checkOutput("rst_mid_sw_data_addr", m_data_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
